// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: physical register geometry, retirement
// tracker sizing defaults and the release FSM state type.
package rename_pkg;

    // Physical register file geometry
    localparam int unsigned PREG_W   = 6;
    localparam int unsigned NUM_PREG = 64;

    // P0 backs architectural x0 and is permanently allocated
    localparam logic [PREG_W-1:0] PREG_ZERO = 6'd0;

    // Retirement tracker sizing defaults
    localparam int unsigned DEPTH_DFLT = 16;
    localparam int unsigned TAG_W_DFLT = 4;

    // Release FSM: normal retirement, or walking back squashed entries
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WALK = 1'b1
    } release_state_e;

endpackage

// File: rtl/release_entry_ram.sv
// Per-entry payload storage for the retirement tracker: destination flag plus
// old and new physical mappings. One synchronous write port (dispatch) and
// two asynchronous read ports (commit head, flush walk pointer).
module release_entry_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PREG_W = 6,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [TAG_W-1:0]  i_wr_idx,
    input  logic              i_wr_has_dest,
    input  logic [PREG_W-1:0] i_wr_old_preg,
    input  logic [PREG_W-1:0] i_wr_new_preg,
    input  logic [TAG_W-1:0]  i_rd_head_idx,
    output logic              o_rd_head_has_dest,
    output logic [PREG_W-1:0] o_rd_head_old_preg,
    input  logic [TAG_W-1:0]  i_rd_walk_idx,
    output logic              o_rd_walk_has_dest,
    output logic [PREG_W-1:0] o_rd_walk_new_preg
);

    logic              r_has_dest [DEPTH];
    logic [PREG_W-1:0] r_old_preg [DEPTH];
    logic [PREG_W-1:0] r_new_preg [DEPTH];

    // Payload is written at dispatch only; validity lives in the tracker
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_has_dest[i_wr_idx] <= i_wr_has_dest;
            r_old_preg[i_wr_idx] <= i_wr_old_preg;
            r_new_preg[i_wr_idx] <= i_wr_new_preg;
        end
    end

    // Head read port feeds commit release, walk read port feeds flush release
    always_comb begin
        o_rd_head_has_dest = r_has_dest[i_rd_head_idx];
        o_rd_head_old_preg = r_old_preg[i_rd_head_idx];
        o_rd_walk_has_dest = r_has_dest[i_rd_walk_idx];
        o_rd_walk_new_preg = r_new_preg[i_rd_walk_idx];
    end

endmodule

// File: rtl/phys_reg_release.sv
// In-order retirement tracker returning physical registers to the free list.
// Commit releases the previous mapping of the head entry; a flush walks the
// squashed entries youngest-first releasing their new mappings, one per cycle.
module phys_reg_release #(
    parameter int unsigned DEPTH  = rename_pkg::DEPTH_DFLT,
    parameter int unsigned PREG_W = rename_pkg::PREG_W,
    parameter int unsigned TAG_W  = rename_pkg::TAG_W_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic              dispatch_has_dest,
    input  logic [PREG_W-1:0] dispatch_old_preg,
    input  logic [PREG_W-1:0] dispatch_new_preg,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    input  logic              flush,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_phys_reg,
    output logic              busy
);

    import rename_pkg::*;

    localparam logic [TAG_W:0]    PTR_ONE   = (TAG_W+1)'(1);
    localparam logic [TAG_W:0]    DEPTH_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [PREG_W-1:0] P0        = PREG_W'(PREG_ZERO);

    release_state_e    r_state;
    logic [TAG_W:0]    r_head;
    logic [TAG_W:0]    r_tail;
    logic [TAG_W:0]    r_walk_ptr;
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic              r_commit_valid;
    logic [TAG_W-1:0]  r_commit_tag;
    logic              r_free_valid;
    logic [PREG_W-1:0] r_free_phys_reg;

    logic [TAG_W:0]    w_count;
    logic [TAG_W-1:0]  w_head_idx;
    logic [TAG_W-1:0]  w_tail_idx;
    logic [TAG_W-1:0]  w_walk_idx;
    logic              w_run;
    logic              w_walk;
    logic              w_ready;
    logic              w_push;
    logic              w_commit;
    logic              w_complete;
    logic              w_flush_go;
    logic              w_walk_last;
    logic              w_head_has_dest;
    logic [PREG_W-1:0] w_head_old_preg;
    logic              w_walk_has_dest;
    logic [PREG_W-1:0] w_walk_new_preg;
    logic              w_commit_free;
    logic              w_walk_free;

    release_entry_ram #(
        .DEPTH  (DEPTH),
        .PREG_W (PREG_W),
        .TAG_W  (TAG_W)
    ) u_ram (
        .clk                (clk),
        .i_wr_en            (w_push),
        .i_wr_idx           (w_tail_idx),
        .i_wr_has_dest      (dispatch_has_dest),
        .i_wr_old_preg      (dispatch_old_preg),
        .i_wr_new_preg      (dispatch_new_preg),
        .i_rd_head_idx      (w_head_idx),
        .o_rd_head_has_dest (w_head_has_dest),
        .o_rd_head_old_preg (w_head_old_preg),
        .i_rd_walk_idx      (w_walk_idx),
        .o_rd_walk_has_dest (w_walk_has_dest),
        .o_rd_walk_new_preg (w_walk_new_preg)
    );

    // Occupancy, handshake and event decode for the current cycle
    always_comb begin
        w_count     = r_tail - r_head;
        w_head_idx  = r_head[TAG_W-1:0];
        w_tail_idx  = r_tail[TAG_W-1:0];
        w_walk_idx  = r_walk_ptr[TAG_W-1:0];
        w_run       = (r_state == RUN);
        w_walk      = (r_state == WALK);
        // Gated by reset so the handshake stays low while reset is held
        w_ready     = reset && w_run && (w_count != DEPTH_CNT) && !flush;
        w_push      = dispatch_valid && w_ready;
        // Uses the registered done bit: a same-cycle complete commits next cycle
        w_commit    = w_run && !flush && r_valid[w_head_idx] && r_done[w_head_idx];
        w_complete  = w_run && !flush && complete_valid && r_valid[complete_tag];
        w_flush_go  = w_run && flush && (w_count != '0);
        w_walk_last = (r_walk_ptr == r_head);
        // P0 is never returned to the free list
        w_commit_free = w_commit && w_head_has_dest && (w_head_old_preg != P0);
        w_walk_free   = w_walk && w_walk_has_dest && (w_walk_new_preg != P0);
    end

    // Pointer and FSM update: normal push/commit in RUN, backward walk in WALK
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= RUN;
            r_head     <= '0;
            r_tail     <= '0;
            r_walk_ptr <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_flush_go) begin
                        r_state    <= WALK;
                        r_walk_ptr <= r_tail - PTR_ONE;
                    end else begin
                        if (w_push) begin
                            r_tail <= r_tail + PTR_ONE;
                        end
                        if (w_commit) begin
                            r_head <= r_head + PTR_ONE;
                        end
                    end
                end
                WALK: begin
                    if (w_walk_last) begin
                        r_tail  <= r_head;
                        r_state <= RUN;
                    end else begin
                        r_walk_ptr <= r_walk_ptr - PTR_ONE;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Entry valid/done tracking; commit clear is ordered after complete so it wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_done  <= '0;
        end else if (w_walk) begin
            r_valid[w_walk_idx] <= 1'b0;
            r_done[w_walk_idx]  <= 1'b0;
        end else begin
            if (w_complete) begin
                r_done[complete_tag] <= 1'b1;
            end
            if (w_commit) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
            end
            if (w_push) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
            end
        end
    end

    // Registered commit and free pulses; commit and walk frees are exclusive by state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit_valid  <= 1'b0;
            r_commit_tag    <= '0;
            r_free_valid    <= 1'b0;
            r_free_phys_reg <= '0;
        end else begin
            r_commit_valid <= w_commit;
            r_commit_tag   <= w_commit ? w_head_idx : '0;
            if (w_commit_free) begin
                r_free_valid    <= 1'b1;
                r_free_phys_reg <= w_head_old_preg;
            end else if (w_walk_free) begin
                r_free_valid    <= 1'b1;
                r_free_phys_reg <= w_walk_new_preg;
            end else begin
                r_free_valid    <= 1'b0;
                r_free_phys_reg <= '0;
            end
        end
    end

    // Output drive
    always_comb begin
        dispatch_ready = w_ready;
        dispatch_tag   = w_tail_idx;
        commit_valid   = r_commit_valid;
        commit_tag     = r_commit_tag;
        free_valid     = r_free_valid;
        free_phys_reg  = r_free_phys_reg;
        busy           = w_walk;
    end

endmodule
